// File: rtl/dsp_xintf_bridge.sv
// Bridge between the DSP XINTF asynchronous strobe bus and the handler's Z2D/D2Z 128x16 buffers,
// with frame handshakes, sticky access-error flag and a commit-rate watchdog.
module dsp_xintf_bridge #(
    parameter int SYNC_STAGES     = 2,
    parameter int Z2D_DONE_ADDR   = 47,
    parameter int D2Z_COMMIT_ADDR = 175,
    parameter int COMMIT_TIMEOUT  = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_z2d_ce,
    input  logic [8:0]  i_z2d_addr,
    input  logic [15:0] i_z2d_din,
    input  logic        i_d2z_ce,
    input  logic [8:0]  i_d2z_addr,
    output logic [15:0] o_d2z_dout,
    input  logic        i_w_valid,
    output logic        o_w_ready,
    output logic        o_r_valid,
    input  logic        i_xintf_cs_n,
    input  logic        i_xintf_rd_n,
    input  logic        i_xintf_we_n,
    input  logic [8:0]  i_xintf_addr,
    input  logic [15:0] i_xintf_data,
    output logic [15:0] o_xintf_data,
    output logic        o_xintf_data_oe,
    output logic        o_access_err,
    output logic        o_dsp_alive
);

    localparam int CW_RAW = $clog2(COMMIT_TIMEOUT + 1);
    localparam int CW     = (CW_RAW > 17) ? CW_RAW : 17;
    localparam logic [CW-1:0] TMO    = CW'(COMMIT_TIMEOUT);
    localparam logic [8:0]    DONE_A = 9'(Z2D_DONE_ADDR);
    localparam logic [8:0]    CMT_A  = 9'(D2Z_COMMIT_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    logic [15:0] z2d_mem [128];
    logic [15:0] d2z_mem [128];

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0] we_sync_q, we_sync_d;
    state_t      state_q, state_d;
    logic [8:0]  addr_q, addr_d;
    logic [15:0] xdata_q, xdata_d;
    logic [15:0] d2z_dout_q, d2z_dout_d;
    logic        wrdy_q, wrdy_d;
    logic        commit_q, commit_d;
    logic        r_valid_q, r_valid_d;
    logic        err_q, err_d;
    logic        alive_q, alive_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic act_rd_s, act_we_s, rd_start_s, wr_start_s, rd_done_s;

    // State register and all handshake/datapath flops; synchronizers park at the inactive level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cs_sync_q  <= '1;
            rd_sync_q  <= '1;
            we_sync_q  <= '1;
            state_q    <= ST_IDLE;
            addr_q     <= 9'd0;
            xdata_q    <= 16'd0;
            d2z_dout_q <= 16'd0;
            wrdy_q     <= 1'b0;
            commit_q   <= 1'b0;
            r_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            alive_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            cs_sync_q  <= cs_sync_d;
            rd_sync_q  <= rd_sync_d;
            we_sync_q  <= we_sync_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            xdata_q    <= xdata_d;
            d2z_dout_q <= d2z_dout_d;
            wrdy_q     <= wrdy_d;
            commit_q   <= commit_d;
            r_valid_q  <= r_valid_d;
            err_q      <= err_d;
            alive_q    <= alive_d;
            cnt_q      <= cnt_d;
        end
    end

    // Buffer write ports; contents survive reset
    always_ff @(posedge i_clk) begin
        if (i_z2d_ce && (i_z2d_addr[8:7] == 2'b00)) begin
            z2d_mem[i_z2d_addr[6:0]] <= i_z2d_din;
        end
        if (wr_start_s && (i_xintf_addr[8:7] == 2'b01)) begin
            d2z_mem[i_xintf_addr[6:0]] <= i_xintf_data;
        end
    end

    // Synchronizer shift and active-strobe decode
    always_comb begin
        cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], i_xintf_cs_n};
        rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], i_xintf_rd_n};
        we_sync_d = {we_sync_q[SYNC_STAGES-2:0], i_xintf_we_n};
        act_rd_s  = ~cs_sync_q[SYNC_STAGES-1] & ~rd_sync_q[SYNC_STAGES-1];
        act_we_s  = ~cs_sync_q[SYNC_STAGES-1] & ~we_sync_q[SYNC_STAGES-1];
    end

    // Next-state logic; simultaneous rd and we overrides every state
    always_comb begin
        state_d = state_q;
        if (act_rd_s && act_we_s) begin
            state_d = ST_ERR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (act_rd_s) begin
                        state_d = ST_RD;
                    end else if (act_we_s) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RD:   state_d = act_rd_s ? ST_RD : ST_IDLE;
                ST_WR:   state_d = act_we_s ? ST_WR : ST_IDLE;
                ST_ERR:  state_d = (act_rd_s || act_we_s) ? ST_ERR : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output and datapath logic derived from state transitions
    always_comb begin
        rd_start_s = (state_q == ST_IDLE) && (state_d == ST_RD);
        wr_start_s = (state_q == ST_IDLE) && (state_d == ST_WR);
        rd_done_s  = (state_q == ST_RD) && (state_d == ST_IDLE);

        addr_d  = (rd_start_s || wr_start_s) ? i_xintf_addr : addr_q;
        xdata_d = xdata_q;
        if (rd_start_s) begin
            case (i_xintf_addr[8:7])
                2'b00:   xdata_d = z2d_mem[i_xintf_addr[6:0]];
                2'b01:   xdata_d = d2z_mem[i_xintf_addr[6:0]];
                default: xdata_d = 16'd0;
            endcase
        end else begin
            xdata_d = xdata_q;
        end

        d2z_dout_d = d2z_dout_q;
        if (i_d2z_ce) begin
            d2z_dout_d = (i_d2z_addr[8:7] == 2'b01) ? d2z_mem[i_d2z_addr[6:0]] : 16'd0;
        end else begin
            d2z_dout_d = d2z_dout_q;
        end

        // Set beats a same-cycle handshake clear
        if (rd_done_s && (addr_q == DONE_A)) begin
            wrdy_d = 1'b1;
        end else if (i_w_valid && wrdy_q) begin
            wrdy_d = 1'b0;
        end else begin
            wrdy_d = wrdy_q;
        end

        commit_d  = wr_start_s && (i_xintf_addr == CMT_A);
        r_valid_d = commit_q;
        err_d     = err_q | (act_rd_s & act_we_s);

        if (commit_q) begin
            cnt_d   = '0;
            alive_d = 1'b1;
        end else if (cnt_q == TMO) begin
            cnt_d   = cnt_q;
            alive_d = 1'b0;
        end else begin
            cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            alive_d = alive_q;
        end
    end

    assign o_xintf_data_oe = (state_q == ST_RD);
    assign o_xintf_data    = xdata_q;
    assign o_d2z_dout      = d2z_dout_q;
    assign o_w_ready       = wrdy_q;
    assign o_r_valid       = r_valid_q;
    assign o_access_err    = err_q;
    assign o_dsp_alive     = alive_q;

endmodule

// File: tb/tb_dsp_xintf_bridge.sv
// Directed self-checking bench for dsp_xintf_bridge (short watchdog timeout to keep the run brief).
module tb_dsp_xintf_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        z2d_ce = 1'b0;
    logic [8:0]  z2d_addr = 9'd0;
    logic [15:0] z2d_din = 16'd0;
    logic        d2z_ce = 1'b0;
    logic [8:0]  d2z_addr = 9'd0;
    logic [15:0] d2z_dout;
    logic        w_valid = 1'b0;
    logic        w_ready, r_valid;
    logic        cs_n = 1'b1, rd_n = 1'b1, we_n = 1'b1;
    logic [8:0]  xaddr = 9'd0;
    logic [15:0] xdin = 16'd0;
    logic [15:0] xdout;
    logic        oe, err, alive;

    int checks = 0;
    int failures = 0;
    int oe_cnt, rv_cnt, n;
    logic [15:0] last_x;

    always #5 clk = ~clk;

    dsp_xintf_bridge #(
        .SYNC_STAGES(2), .Z2D_DONE_ADDR(47), .D2Z_COMMIT_ADDR(175), .COMMIT_TIMEOUT(300)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_z2d_ce(z2d_ce), .i_z2d_addr(z2d_addr), .i_z2d_din(z2d_din),
        .i_d2z_ce(d2z_ce), .i_d2z_addr(d2z_addr), .o_d2z_dout(d2z_dout),
        .i_w_valid(w_valid), .o_w_ready(w_ready), .o_r_valid(r_valid),
        .i_xintf_cs_n(cs_n), .i_xintf_rd_n(rd_n), .i_xintf_we_n(we_n),
        .i_xintf_addr(xaddr), .i_xintf_data(xdin), .o_xintf_data(xdout),
        .o_xintf_data_oe(oe), .o_access_err(err), .o_dsp_alive(alive)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One DSP strobe held nclk clocks, then 6 idle clocks; counts oe/r_valid cycles
    task automatic dsp_access(input logic rd, input logic we, input logic [8:0] a,
                              input logic [15:0] d, input int nclk, input bit collide);
        @(negedge clk);
        cs_n = 1'b0; rd_n = ~rd; we_n = ~we; xaddr = a; xdin = d;
        oe_cnt = 0; rv_cnt = 0; last_x = 16'd0;
        for (int i = 1; i <= nclk + 6; i++) begin
            @(negedge clk);
            if (oe) begin oe_cnt++; last_x = xdout; end
            if (r_valid) rv_cnt++;
            if (collide && i == 2) begin z2d_ce = 1'b1; z2d_addr = a; z2d_din = 16'h5678; end
            if (collide && i == 3) z2d_ce = 1'b0;
            if (i == nclk) begin cs_n = 1'b1; rd_n = 1'b1; we_n = 1'b1; end
        end
    endtask

    task automatic hread(input logic [8:0] a);
        @(negedge clk);
        d2z_ce = 1'b1; d2z_addr = a;
        @(negedge clk);
        d2z_ce = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_oe", oe, 1'b0);
        chk("rst_rvalid", r_valid, 1'b0);
        chk("rst_wready", w_ready, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_alive", alive, 1'b0);
        chk("rst_xdata", xdout, 16'h0000);
        chk("rst_dout", d2z_dout, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        z2d_ce = 1'b1; z2d_addr = 9'd8; z2d_din = 16'h1234;
        @(negedge clk);
        z2d_ce = 1'b0;

        dsp_access(1'b1, 1'b0, 9'd8, 16'h0000, 5, 1'b0);
        chk("rd8_data", last_x, 16'h1234);
        chk("rd8_oe_cycles", oe_cnt, 5);
        chk("rd8_oe_after", oe, 1'b0);
        chk("rd8_no_wready", w_ready, 1'b0);
        chk("alive_before_commit", alive, 1'b0);

        dsp_access(1'b0, 1'b1, 9'd129, 16'hBEEF, 5, 1'b0);
        chk("wr129_no_rvalid", rv_cnt, 0);
        chk("wr_no_oe", oe_cnt, 0);
        dsp_access(1'b0, 1'b1, 9'd175, 16'h0001, 5, 1'b0);
        chk("commit_rvalid_pulses", rv_cnt, 1);
        chk("alive_after_commit", alive, 1'b1);
        hread(9'd129);
        chk("hread129", d2z_dout, 16'hBEEF);
        @(negedge clk);
        d2z_addr = 9'd175;
        @(negedge clk);
        chk("dout_hold", d2z_dout, 16'hBEEF);
        hread(9'd175);
        chk("hread175", d2z_dout, 16'h0001);
        dsp_access(1'b1, 1'b0, 9'd129, 16'h0000, 5, 1'b0);
        chk("dsp_readback129", last_x, 16'hBEEF);

        dsp_access(1'b1, 1'b0, 9'd47, 16'h0000, 5, 1'b0);
        chk("wready_set", w_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk("wready_hold", w_ready, 1'b1);
        w_valid = 1'b1;
        @(negedge clk);
        chk("wready_clear", w_ready, 1'b0);
        w_valid = 1'b0;

        dsp_access(1'b0, 1'b1, 9'd130, 16'h5555, 5, 1'b0);
        dsp_access(1'b1, 1'b1, 9'd130, 16'hDEAD, 5, 1'b0);
        chk("err_set", err, 1'b1);
        chk("err_no_oe", oe_cnt, 0);
        chk("err_no_rvalid", rv_cnt, 0);
        hread(9'd130);
        chk("err_no_write", d2z_dout, 16'h5555);
        dsp_access(1'b1, 1'b0, 9'd8, 16'h0000, 5, 1'b1);
        chk("collide_read_first", last_x, 16'h1234);
        chk("err_sticky", err, 1'b1);
        dsp_access(1'b1, 1'b0, 9'd8, 16'h0000, 5, 1'b0);
        chk("collide_new_data", last_x, 16'h5678);

        dsp_access(1'b0, 1'b1, 9'd175, 16'h0002, 5, 1'b0);
        n = 0;
        while (alive && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("watchdog_dropped", alive, 1'b0);
        chk("watchdog_timing", (n >= 285 && n <= 300), 1'b1);
        dsp_access(1'b0, 1'b1, 9'd175, 16'h0003, 5, 1'b0);
        chk("watchdog_recover", alive, 1'b1);

        dsp_access(1'b0, 1'b1, 9'd172, 16'h7777, 5, 1'b0);
        dsp_access(1'b0, 1'b1, 9'd300, 16'hAAAA, 5, 1'b0);
        hread(9'd172);
        chk("addr300_no_write", d2z_dout, 16'h7777);
        dsp_access(1'b1, 1'b0, 9'd300, 16'h0000, 5, 1'b0);
        chk("addr300_read_zero", last_x, 16'h0000);

        dsp_access(1'b1, 1'b0, 9'd47, 16'h0000, 5, 1'b0);
        chk("wready_preset", w_ready, 1'b1);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; xaddr = 9'd8;
        repeat (4) @(negedge clk);
        chk("midrd_oe", oe, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_oe_drop", oe, 1'b0);
        chk("async_err_clr", err, 1'b0);
        chk("async_wready_clr", w_ready, 1'b0);
        chk("async_alive_clr", alive, 1'b0);
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dsp_access(1'b1, 1'b0, 9'd8, 16'h0000, 5, 1'b0);
        chk("ram_kept_z2d", last_x, 16'h5678);
        hread(9'd129);
        chk("ram_kept_d2z", d2z_dout, 16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
